// File: rtl/snake_body_if.sv
// Control and status bundle between the game controller and the snake body engine.
interface snake_body_if #(
    parameter int unsigned MAX_LEN = 64
);
    localparam int unsigned LW = $clog2(MAX_LEN) + 1;

    logic                  tick;
    logic [1:0]            dir;
    logic                  grow;
    logic                  restart;
    logic [15:0][15:0]     grid;
    logic [3:0]            head_x;
    logic [3:0]            head_y;
    logic [LW-1:0]         length;
    logic                  busy;
    logic                  game_over;

    modport master (
        output tick, dir, grow, restart,
        input  grid, head_x, head_y, length, busy, game_over
    );

    modport slave (
        input  tick, dir, grow, restart,
        output grid, head_x, head_y, length, busy, game_over
    );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body engine: circular segment buffer, wall/self collision detection and an
// incrementally maintained 16x16 occupancy bitmap that is a complete frame at every edge.
module snake_body_engine #(
    parameter int unsigned MAX_LEN  = 64,
    parameter int unsigned INIT_LEN = 3
) (
    input  logic         clk,
    input  logic         reset,
    snake_body_if.slave  bus
);
    localparam int unsigned PW = $clog2(MAX_LEN);
    localparam int unsigned LW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_MOVE,
        S_OVER
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        heading_q, heading_d;
    logic [4:0]        nx_q, nx_d;
    logic [4:0]        ny_q, ny_d;
    logic [PW-1:0]     head_ptr_q, head_ptr_d;
    logic [PW-1:0]     tail_ptr_q, tail_ptr_d;
    logic [LW-1:0]     length_q, length_d;
    logic              grow_pend_q, grow_pend_d;
    logic [15:0][15:0] grid_q, grid_d;
    logic [3:0]        head_x_q, head_x_d;
    logic [3:0]        head_y_q, head_y_d;

    logic [3:0]        seg_x_q [MAX_LEN];
    logic [3:0]        seg_y_q [MAX_LEN];

    logic [1:0]        hd;
    logic [3:0]        tail_x, tail_y;
    logic              room;
    logic              grow_chk, grow_mv;
    logic              tail_hit;
    logic              seg_we;

    function automatic logic [15:0][15:0] init_grid();
        logic [15:0][15:0] g;
        g = '0;
        for (int unsigned i = 0; i < INIT_LEN; i++) begin
            g[7][4'(8 - INIT_LEN + i)] = 1'b1;
        end
        return g;
    endfunction

    assign tail_x   = seg_x_q[tail_ptr_q];
    assign tail_y   = seg_y_q[tail_ptr_q];
    assign room     = (length_q < LW'(MAX_LEN));
    // A grow pulse arriving during CHECK is consumed by the move in flight.
    assign grow_chk = (grow_pend_q | bus.grow) & room;
    assign grow_mv  = grow_pend_q & room;
    assign tail_hit = (nx_q[3:0] == tail_x) && (ny_q[3:0] == tail_y);

    always_comb begin
        state_d     = state_q;
        heading_d   = heading_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        head_ptr_d  = head_ptr_q;
        tail_ptr_d  = tail_ptr_q;
        length_d    = length_q;
        grow_pend_d = grow_pend_q;
        grid_d      = grid_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        seg_we      = 1'b0;
        hd          = heading_q;

        if (state_q != S_OVER && bus.grow) begin
            grow_pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.tick) begin
                    hd        = (bus.dir == (heading_q ^ 2'd2)) ? heading_q : bus.dir;
                    heading_d = hd;
                    nx_d      = {1'b0, head_x_q};
                    ny_d      = {1'b0, head_y_q};
                    unique case (hd)
                        2'd0: nx_d = {1'b0, head_x_q} + 5'd1;
                        2'd1: ny_d = {1'b0, head_y_q} + 5'd1;
                        2'd2: nx_d = {1'b0, head_x_q} - 5'd1;
                        2'd3: ny_d = {1'b0, head_y_q} - 5'd1;
                    endcase
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Bit 4 set means the 5-bit step left the 0..15 range in either direction.
                if (nx_q[4] || ny_q[4]) begin
                    state_d = S_OVER;
                end else if (grid_q[ny_q[3:0]][nx_q[3:0]] && !(tail_hit && !grow_chk)) begin
                    state_d = S_OVER;
                end else begin
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                head_ptr_d = head_ptr_q + 1'b1;
                seg_we     = 1'b1;
                if (grow_mv) begin
                    length_d = length_q + 1'b1;
                end else begin
                    grid_d[tail_y][tail_x] = 1'b0;
                    tail_ptr_d = tail_ptr_q + 1'b1;
                end
                // Head set after tail clear so a head moving into the vacated tail keeps the bit.
                grid_d[ny_q[3:0]][nx_q[3:0]] = 1'b1;
                head_x_d    = nx_q[3:0];
                head_y_d    = ny_q[3:0];
                grow_pend_d = bus.grow;
                state_d     = S_IDLE;
            end
            S_OVER: begin
            end
        endcase

        if (bus.restart) begin
            state_d     = S_IDLE;
            heading_d   = 2'd0;
            nx_d        = '0;
            ny_d        = '0;
            head_ptr_d  = PW'(INIT_LEN - 1);
            tail_ptr_d  = '0;
            length_d    = LW'(INIT_LEN);
            grow_pend_d = 1'b0;
            grid_d      = init_grid();
            head_x_d    = 4'd7;
            head_y_d    = 4'd7;
            seg_we      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            heading_q   <= 2'd0;
            nx_q        <= '0;
            ny_q        <= '0;
            head_ptr_q  <= PW'(INIT_LEN - 1);
            tail_ptr_q  <= '0;
            length_q    <= LW'(INIT_LEN);
            grow_pend_q <= 1'b0;
            grid_q      <= init_grid();
            head_x_q    <= 4'd7;
            head_y_q    <= 4'd7;
        end else begin
            state_q     <= state_d;
            heading_q   <= heading_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            head_ptr_q  <= head_ptr_d;
            tail_ptr_q  <= tail_ptr_d;
            length_q    <= length_d;
            grow_pend_q <= grow_pend_d;
            grid_q      <= grid_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_q[PW'(i)] <= (i < INIT_LEN) ? 4'(8 - INIT_LEN + i) : 4'd0;
                seg_y_q[PW'(i)] <= (i < INIT_LEN) ? 4'd7 : 4'd0;
            end
        end else if (bus.restart) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_q[PW'(i)] <= (i < INIT_LEN) ? 4'(8 - INIT_LEN + i) : 4'd0;
                seg_y_q[PW'(i)] <= (i < INIT_LEN) ? 4'd7 : 4'd0;
            end
        end else if (seg_we) begin
            seg_x_q[head_ptr_d] <= nx_q[3:0];
            seg_y_q[head_ptr_d] <= ny_q[3:0];
        end
    end

    assign bus.grid      = grid_q;
    assign bus.head_x    = head_x_q;
    assign bus.head_y    = head_y_q;
    assign bus.length    = length_q;
    assign bus.busy      = (state_q == S_CHECK) || (state_q == S_MOVE);
    assign bus.game_over = (state_q == S_OVER);
endmodule

// File: tb/tb_snake_body_engine.sv
// Directed and randomized bench for snake_body_engine against a queue-based snake model.
module tb_snake_body_engine;
    localparam int unsigned MAX_LEN  = 64;
    localparam int unsigned INIT_LEN = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    snake_body_if #(.MAX_LEN(MAX_LEN)) bus ();

    snake_body_engine #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: body cells in queues, tail at index 0, head at the back.
    int mx[$];
    int my[$];
    int m_head;
    bit m_pend;
    bit m_over;

    function automatic void m_init();
        mx.delete();
        my.delete();
        for (int i = 0; i < int'(INIT_LEN); i++) begin
            mx.push_back(8 - int'(INIT_LEN) + i);
            my.push_back(7);
        end
        m_head = 0;
        m_pend = 1'b0;
        m_over = 1'b0;
    endfunction

    function automatic logic [255:0] m_grid();
        logic [255:0] g;
        g = '0;
        foreach (mx[i]) g[my[i] * 16 + mx[i]] = 1'b1;
        return g;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag);
        logic [255:0] g;
        g = bus.grid;
        chk({tag, "_hx"}, 256'(bus.head_x), 256'(mx[mx.size() - 1]));
        chk({tag, "_hy"}, 256'(bus.head_y), 256'(my[my.size() - 1]));
        chk({tag, "_len"}, 256'(bus.length), 256'(mx.size()));
        chk({tag, "_grid"}, g, m_grid());
        chk({tag, "_pop"}, 256'($countones(g)), 256'(mx.size()));
        chk({tag, "_over"}, 256'(bus.game_over), 256'(m_over));
    endtask

    task automatic do_move(input int d, input bit g, input bit gmid);
        bit over0, coll, wg;
        int h, nx, ny;
        @(negedge clk);
        bus.tick = 1'b1;
        bus.dir  = d[1:0];
        bus.grow = g;
        @(negedge clk);
        bus.tick = 1'b0;
        bus.grow = 1'b0;
        over0 = m_over;
        coll  = 1'b0;
        wg    = 1'b0;
        nx    = 0;
        ny    = 0;
        if (!m_over) begin
            m_pend = m_pend | g;
            h = (d == (m_head ^ 2)) ? m_head : d;
            m_head = h;
            nx = mx[mx.size() - 1] + ((h == 0) ? 1 : 0) - ((h == 2) ? 1 : 0);
            ny = my[my.size() - 1] + ((h == 1) ? 1 : 0) - ((h == 3) ? 1 : 0);
            wg = m_pend && (mx.size() < int'(MAX_LEN));
            if (nx < 0 || nx > 15 || ny < 0 || ny > 15) coll = 1'b1;
            else foreach (mx[i]) if (mx[i] == nx && my[i] == ny && !(i == 0 && !wg)) coll = 1'b1;
        end
        chk("busy_e0", 256'(bus.busy), 256'(!over0));
        @(negedge clk);
        chk("busy_e1", 256'(bus.busy), 256'(!over0 && !coll));
        if (gmid) bus.grow = 1'b1;
        @(negedge clk);
        bus.grow = 1'b0;
        chk("busy_e2", 256'(bus.busy), 256'(0));
        if (!over0) begin
            if (coll) begin
                m_over = 1'b1;
            end else begin
                mx.push_back(nx);
                my.push_back(ny);
                if (!wg) begin
                    void'(mx.pop_front());
                    void'(my.pop_front());
                end
                m_pend = gmid;
            end
        end
        check_frame("move");
    endtask

    task automatic do_grow();
        @(negedge clk);
        bus.grow = 1'b1;
        @(negedge clk);
        bus.grow = 1'b0;
        if (!m_over) m_pend = 1'b1;
    endtask

    task automatic do_restart();
        @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        m_init();
        check_frame("restart");
        chk("restart_busy", 256'(bus.busy), 256'(0));
    endtask

    function automatic int serp_dir();
        int x;
        x = mx[mx.size() - 1];
        if (m_head == 0) return (x == 15) ? 3 : 0;
        if (m_head == 2) return (x == 0) ? 3 : 2;
        return (x == 15) ? 2 : 0;
    endfunction

    initial begin
        reset       = 1'b1;
        bus.tick    = 1'b0;
        bus.dir     = 2'd0;
        bus.grow    = 1'b0;
        bus.restart = 1'b0;
        m_init();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_frame("reset");
        chk("reset_busy", 256'(bus.busy), 256'(0));

        // Straight run right.
        repeat (3) do_move(0, 1'b0, 1'b0);
        chk("run_hx", 256'(bus.head_x), 256'(10));

        // Grow then turn down; a grow during MOVE lands on the following move.
        do_restart();
        do_grow();
        do_move(1, 1'b0, 1'b1);
        chk("grow_len4", 256'(bus.length), 256'(4));
        do_move(2, 1'b0, 1'b0);
        chk("grow_len5", 256'(bus.length), 256'(5));

        // Reverse request is ignored, then run into the right wall.
        do_restart();
        do_move(2, 1'b0, 1'b0);
        chk("rev_hx", 256'(bus.head_x), 256'(8));
        repeat (8) do_move(0, 1'b0, 1'b0);
        chk("wall_over", 256'(bus.game_over), 256'(1));
        do_move(1, 1'b1, 1'b0);
        do_restart();

        // Self collision with length 5.
        do_move(0, 1'b1, 1'b0);
        do_move(0, 1'b1, 1'b0);
        do_move(1, 1'b0, 1'b0);
        do_move(2, 1'b0, 1'b0);
        do_move(3, 1'b0, 1'b0);
        chk("self_over", 256'(bus.game_over), 256'(1));

        // Length 4 chasing its tail around a 2x2 loop.
        do_restart();
        do_grow();
        do_move(1, 1'b0, 1'b0);
        do_move(2, 1'b0, 1'b0);
        do_move(3, 1'b0, 1'b0);
        do_move(0, 1'b0, 1'b0);
        do_move(1, 1'b0, 1'b0);
        do_move(2, 1'b0, 1'b0);
        chk("loop_over", 256'(bus.game_over), 256'(0));
        chk("loop_len", 256'(bus.length), 256'(4));

        // Asynchronous reset in the middle of a move.
        do_restart();
        @(negedge clk);
        bus.tick = 1'b1;
        bus.dir  = 2'd1;
        @(negedge clk);
        bus.tick = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        m_init();
        check_frame("async_rst");
        chk("async_rst_busy", 256'(bus.busy), 256'(0));
        @(negedge clk);
        reset = 1'b0;

        // Serpentine with growth on every move saturates at MAX_LEN with pointer wrap.
        do_restart();
        for (int k = 0; k < 72; k++) do_move(serp_dir(), 1'b1, 1'b0);
        chk("sat_len", 256'(bus.length), 256'(MAX_LEN));
        chk("sat_over", 256'(bus.game_over), 256'(0));

        // Randomized moves and grow pulses.
        do_restart();
        for (int k = 0; k < 80; k++) begin
            if (m_over) do_restart();
            if ($urandom_range(0, 5) == 0) do_grow();
            do_move(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
- Game-core stage directly upstream of the 16x16 LED matrix driver.
- Holds the snake as a circular buffer of segment coordinates and advances it one cell per move tick.
- Detects wall and self collision, and incrementally maintains the 16x16 occupancy bitmap the matrix driver serialises.
- `grid` is always a complete, consistent frame, so the display can sample it at any time.

Parameters:
- MAX_LEN, 64, capacity of the segment buffer; must be a power of two, 4..256.
- INIT_LEN, 3, snake length after reset or restart; must be 2..MAX_LEN and at most 8.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  single-cycle move request from the game timer.
- dir  input  2  requested heading: 0=right(+x), 1=down(+y), 2=left(-x), 3=up(-y).
- grow  input  1  single-cycle pulse; the snake lengthens by one on the next accepted move.
- restart  input  1  single-cycle pulse; re-initialises the game from any state.
- grid  output  [15:0][15:0]  occupancy bitmap, grid[y][x]=1 means a segment occupies the cell; y=row, x=column.
- head_x  output  4  current head column.
- head_y  output  4  current head row.
- length  output  $clog2(MAX_LEN)+1  current segment count.
- busy  output  1  high while a move is in progress; a tick is ignored while busy is high.
- game_over  output  1  high after a collision until restart or reset.

Behaviour:
- Reset and restart values (reset is asynchronous; restart takes effect on the next posedge):
  - Segments occupy row 7, columns 8-INIT_LEN .. 7; head=(7,7), tail=(8-INIT_LEN,7).
  - Heading = right; length=INIT_LEN; busy=0; game_over=0; grow_pending=0.
  - grid contains only those INIT_LEN bits; head_ptr=INIT_LEN-1, tail_ptr=0.
- restart has priority over every other input and state, including mid-move.
- State machine has four states: IDLE, CHECK, MOVE, OVER.
- IDLE:
  - On an edge with tick=1, latch the heading and go to CHECK.
  - A requested dir that is the exact reverse of the current heading is ignored; the current heading is kept.
  - Compute the next head with 5-bit arithmetic: x+1, x-1, y+1, y-1 per heading.
- CHECK (one cycle):
  - Out of bounds: the next coordinate is below 0 or above 15 (no wrap-around). Go to OVER.
  - Self collision: grid[ny][nx]=1. Go to OVER.
    - Exception: if that cell is the current tail and no growth will occur this move, it is not a collision.
  - Otherwise go to MOVE.
- MOVE (one cycle):
  - Increment head_ptr modulo MAX_LEN; store (nx,ny) there; set grid[ny][nx]; update head_x/head_y.
  - If grow_pending=1 and length<MAX_LEN: length+1, tail stays in place.
  - Otherwise: clear the grid bit of the tail cell and increment tail_ptr modulo MAX_LEN.
  - In both cases clear grow_pending.
  - If the new head equals the vacated tail cell, the set wins and the bit stays 1.
  - Return to IDLE.
- OVER: game_over=1; grid, head and length are frozen; tick and grow are ignored. Exit only via restart or reset.
- busy=1 in CHECK and MOVE.
- Latency: tick sampled at edge E0 → collision decision at E1 → grid/head/length updated at E2; busy is high from E0 to E2.
- grow:
  - Sampled on any edge in any non-OVER state; sets the sticky grow_pending.
  - Multiple grow pulses before a move collapse into one growth.
  - At length=MAX_LEN, growth is dropped and grow_pending is cleared.
- Simultaneous events:
  - tick together with grow in IDLE: this move grows.
  - grow arriving during CHECK/MOVE applies to the next move, unless it is already consumed by the current MOVE.
- Invariant: popcount(grid) == length at every edge outside the MOVE transition.

Test Plan:
- Reset, then 3 ticks with dir=0 → head=(10,7), length=3, grid row 7 = bits 8..10 only; busy high exactly 2 cycles after each tick.
- From reset: grow pulse, tick dir=1 → head=(7,8), length=4, grid bits (5,7),(6,7),(7,7),(7,8); second grow during busy applies to the following tick.
- Heading right, tick with dir=2 → reverse ignored, head=(8,7).
- Drive right until x=15, one more tick → game_over=1 two cycles later, grid unchanged, further ticks ignored; restart → initial frame restored, game_over=0.
- With length 5, a path into its own body → game_over. With length 4 in a 2x2 loop (head moving into the tail cell, no grow) → no collision, length stays 4.
- Assert reset mid-MOVE → asynchronous return to the initial frame. Grow MAX_LEN times → length saturates at MAX_LEN and pointers wrap correctly (grid popcount == length).
